// File: rtl/mux_channel_scanner.sv
// Sequencer and capture stage for a 4-to-1 line mux: steps select through channels
// 0..3, samples the mux output after SETTLE cycles each, and hands off a 4-bit word.
module mux_channel_scanner #(
  parameter int SETTLE     = 2,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       m_in,
  output logic [1:0] select,
  output logic       busy,
  output logic [3:0] scan_word,
  output logic       word_valid,
  input  logic       word_ready
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    assembly;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; the small assembly buffer is reset too, since it is just flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      select     <= 2'b00;
      busy       <= 1'b0;
      scan_word  <= 4'b0000;
      word_valid <= 1'b0;
      cnt        <= '0;
      assembly   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            select <= 2'b00;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end

        SCAN: begin
          // Only the last settle cycle of each channel is sampled.
          if (cnt == CNT_LAST) begin
            cnt              <= '0;
            assembly[select] <= m_in;
            if (select != 2'd3) begin
              select <= select + 2'd1;
            end else begin
              scan_word  <= {m_in, assembly[2:0]};
              word_valid <= 1'b1;
              select     <= 2'b00;
              state      <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (CONTINUOUS) begin
              state  <= SCAN;
              select <= 2'b00;
              cnt    <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: one one-shot and one continuous instance, checked
// every cycle against a timeline model plus directed literal expectations.
module tb_mux_channel_scanner;

  localparam int S = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] mux_in;
  logic [1:0] start_v, ready_v, m_in_v;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b, valid_a, valid_b;
  logic [3:0] word_a, word_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic checking = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign m_in_v[0] = mux_in[sel_a];
  assign m_in_v[1] = mux_in[sel_b];

  mux_channel_scanner #(.SETTLE(S), .CONTINUOUS(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start_v[0]), .m_in(m_in_v[0]),
    .select(sel_a), .busy(busy_a), .scan_word(word_a), .word_valid(valid_a),
    .word_ready(ready_v[0])
  );

  mux_channel_scanner #(.SETTLE(S), .CONTINUOUS(1'b1)) dut_c (
    .clock(clock), .reset(reset), .start(start_v[1]), .m_in(m_in_v[1]),
    .select(sel_b), .busy(busy_b), .scan_word(word_b), .word_valid(valid_b),
    .word_ready(ready_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: mode 0 idle, 1 scanning (pos = edges since scan began), 2 holding a word.
  int         m_mode[2], m_pos[2];
  logic [3:0] m_samp[2], m_word[2];
  logic       m_valid[2];
  int         t_md, t_p;
  logic [3:0] t_s, t_w;
  logic       t_v;

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      t_md = m_mode[k]; t_p = m_pos[k]; t_s = m_samp[k]; t_w = m_word[k]; t_v = m_valid[k];
      if (reset) begin
        t_md = 0; t_p = 0; t_s = 4'h0; t_w = 4'h0; t_v = 1'b0;
      end else if (t_md == 0) begin
        if (start_v[k]) begin t_md = 1; t_p = 0; end
      end else if (t_md == 1) begin
        if ((t_p + 1) % S == 0) t_s[2'(t_p / S)] = mux_in[2'(t_p / S)];
        t_p++;
        if (t_p == 4 * S) begin t_w = t_s; t_v = 1'b1; t_md = 2; end
      end else if (ready_v[k]) begin
        t_v = 1'b0; t_p = 0; t_md = (k == 1) ? 1 : 0;
      end
      m_mode[k] <= t_md; m_pos[k] <= t_p; m_samp[k] <= t_s; m_word[k] <= t_w; m_valid[k] <= t_v;
    end
  end

  function automatic int exp_sel(input int k);
    return (m_mode[k] == 1) ? m_pos[k] / S : 0;
  endfunction

  always @(negedge clock) begin
    if (checking) begin
      check("a_select", 32'(sel_a), 32'(exp_sel(0)));
      check("a_busy",   32'(busy_a), 32'(m_mode[0] != 0));
      check("a_valid",  32'(valid_a), 32'(m_valid[0]));
      check("a_word",   32'(word_a), 32'(m_word[0]));
      check("b_select", 32'(sel_b), 32'(exp_sel(1)));
      check("b_busy",   32'(busy_b), 32'(m_mode[1] != 0));
      check("b_valid",  32'(valid_b), 32'(m_valid[1]));
      check("b_word",   32'(word_b), 32'(m_word[1]));
    end
  end

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(negedge clock);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_sel_a(input logic [1:0] s);
    int n = 0;
    while (sel_a != s && n < 40) begin @(negedge clock); n++; end
    check("wait_select_a", 32'(sel_a == s), 32'd1);
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (((k == 0) ? valid_a : valid_b) !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    check("wait_valid", 32'((k == 0) ? valid_a : valid_b), 32'd1);
  endtask

  initial begin
    logic [1:0] seq [8];
    int n, lat, t1;
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    reset = 1'b1; mux_in = 4'b1010; start_v = 2'b00; ready_v = 2'b00;
    repeat (2) @(negedge clock);
    checking = 1'b1;
    check("rst_select", 32'(sel_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_word", 32'(word_a), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: ins 0,1,0,1 with ready high; select sequence and 8-edge latency.
    ready_v[0] = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 8; i++) begin
      check("t1_select_seq", 32'(sel_a), 32'(seq[i]));
      check("t1_valid_low", 32'(valid_a), 32'd0);
      @(negedge clock);
    end
    check("t1_valid", 32'(valid_a), 32'd1);
    check("t1_word", 32'(word_a), 32'hA);
    @(negedge clock);
    check("t1_idle_busy", 32'(busy_a), 32'd0);

    // 2: downstream stalls for 20 cycles.
    ready_v[0] = 1'b0;
    pulse_start(0);
    wait_valid(0);
    for (int i = 0; i < 20; i++) begin
      check("t2_hold_valid", 32'(valid_a), 32'd1);
      check("t2_hold_word", 32'(word_a), 32'hA);
      check("t2_hold_busy", 32'(busy_a), 32'd1);
      @(negedge clock);
    end
    ready_v[0] = 1'b1;
    @(negedge clock);
    check("t2_release_busy", 32'(busy_a), 32'd0);
    check("t2_release_valid", 32'(valid_a), 32'd0);

    // 3: in_3 is 1 on the first settle cycle of channel 3 and 0 on the second.
    pulse_start(0);
    wait_sel_a(2'd3);
    @(negedge clock);
    mux_in[3] = 1'b0;
    wait_valid(0);
    check("t3_word", 32'(word_a), 32'h2);
    mux_in[3] = 1'b1;
    @(negedge clock);

    // 4: a second start mid-scan is ignored.
    pulse_start(0);
    wait_sel_a(2'd1);
    pulse_start(0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid_a) n++;
      @(negedge clock);
    end
    check("t4_word_count", 32'(n), 32'd1);
    check("t4_idle", 32'(busy_a), 32'd0);

    // 5: reset mid-scan, then a fresh full scan.
    pulse_start(0);
    wait_sel_a(2'd2);
    reset = 1'b1;
    @(negedge clock);
    check("t5_select", 32'(sel_a), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_valid", 32'(valid_a), 32'd0);
    check("t5_word", 32'(word_a), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    pulse_start(0);
    lat = 0;
    while (!valid_a && lat < 20) begin @(negedge clock); lat++; end
    check("t5_latency", 32'(lat), 32'd8);
    check("t5_word_after", 32'(word_a), 32'hA);
    @(negedge clock);

    // 6: continuous instance, inputs changed between scans.
    ready_v[1] = 1'b1;
    pulse_start(1);
    wait_valid(1);
    check("t6_word1", 32'(word_b), 32'hA);
    t1 = cyc;
    mux_in = 4'b0011;
    @(negedge clock);
    wait_valid(1);
    check("t6_word2", 32'(word_b), 32'h3);
    check("t6_spacing", 32'(cyc - t1), 32'd9);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
